// File: rtl/fpu_sched.sv
// fpu_sched: two-requester round-robin scheduler in front of a single
// multi-cycle FPU. One operation is outstanding at a time:
//   IDLE -> LAUNCH (unit held in reset) -> WAIT (unit active) -> RESP.
// Opcodes above 4 never reach the FPU; they get an immediate "invalid"
// response instead.
//
// Optional build macro: FPU_SCHED_TIMEOUT_EN adds a WAIT-state watchdog that
// aborts the operation after TIMEOUT_CYCLES cycles without fpu_done.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   req_valid/req_ready  per-requester request / one-cycle grant strobe
//   req_op/a/b/rm        packed per-requester opcode, operands, rounding mode
//   fpu_in1/in2/opcode/round/rstp/act/en   drive side of the FPU
//   fpu_out/flags/done   FPU result side
//   rsp_valid/ready      response handshake
//   rsp_id/data/flags/timeout              response payload
//   busy                 high whenever the scheduler is not IDLE
module fpu_sched #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [5:0]  req_op,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [5:0]  req_rm,
  output logic [31:0] fpu_in1,
  output logic [31:0] fpu_in2,
  output logic [2:0]  fpu_opcode,
  output logic [2:0]  fpu_round,
  output logic        fpu_rstp,
  output logic        fpu_act,
  output logic [4:0]  fpu_en,
  input  logic [31:0] fpu_out,
  input  logic [7:0]  fpu_flags,
  input  logic        fpu_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic [7:0]  rsp_flags,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam logic [7:0] FLAG_INV = 8'h20;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last;
  logic        r_id;
  logic [2:0]  r_op;
  logic [2:0]  r_rm;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_data;
  logic [7:0]  r_flags;

  logic        w_grant;
  logic        w_gnt_id;
  logic [2:0]  w_gnt_op;
  logic        w_op_bad;
  logic        w_tmo_hit;

  // Unit-enable bit order differs from opcode order (sqrt and div swap).
  function automatic logic [4:0] op_to_en(input logic [2:0] op);
    case (op)
      3'd0:    op_to_en = 5'b00001;
      3'd1:    op_to_en = 5'b00010;
      3'd2:    op_to_en = 5'b01000;
      3'd3:    op_to_en = 5'b00100;
      3'd4:    op_to_en = 5'b10000;
      default: op_to_en = 5'b00000;
    endcase
  endfunction

  // Tie goes to the requester not served last; a lone requester always wins.
  assign w_gnt_id = (req_valid == 2'b11) ? ~r_last : ~req_valid[0];
  assign w_gnt_op = w_gnt_id ? req_op[5:3] : req_op[2:0];
  assign w_op_bad = (w_gnt_op > 3'd4);
  // rstn gate keeps the combinational strobe quiet while reset is held.
  assign w_grant  = (r_state == S_IDLE) && (|req_valid) && rstn;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 2'b00;
    fpu_rstp  = 1'b1;
    fpu_act   = 1'b0;
    fpu_en    = 5'b00000;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          req_ready = w_gnt_id ? 2'b10 : 2'b01;
          w_next    = w_op_bad ? S_RESP : S_LAUNCH;
        end
      end
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT: begin
        fpu_rstp = 1'b0;
        fpu_act  = 1'b1;
        fpu_en   = op_to_en(r_op);
        if (fpu_done || w_tmo_hit) w_next = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Grant latch and result capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_op    <= 3'd0;
      r_rm    <= 3'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_data  <= 32'd0;
      r_flags <= 8'd0;
    end else begin
      if (w_grant) begin
        r_id   <= w_gnt_id;
        r_last <= w_gnt_id;
        r_op   <= w_gnt_op;
        r_rm   <= w_gnt_id ? req_rm[5:3]  : req_rm[2:0];
        r_a    <= w_gnt_id ? req_a[63:32] : req_a[31:0];
        r_b    <= w_gnt_id ? req_b[63:32] : req_b[31:0];
        if (w_op_bad) begin
          r_data  <= 32'd0;
          r_flags <= FLAG_INV;
        end
      end
      if (r_state == S_WAIT) begin
        if (fpu_done) begin
          r_data  <= fpu_out;
          r_flags <= fpu_flags;
        end else if (w_tmo_hit) begin
          r_data  <= 32'd0;
          r_flags <= 8'd0;
        end
      end
    end
  end

`ifdef FPU_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_tmo_cnt;
  logic          r_tmo;

  // Counter value equals the number of WAIT cycles already completed.
  assign w_tmo_hit = (r_state == S_WAIT) && (r_tmo_cnt == TMO_LAST);

  // Watchdog
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tmo_cnt <= '0;
      r_tmo     <= 1'b0;
    end else begin
      if ((r_state == S_WAIT) && !fpu_done) r_tmo_cnt <= r_tmo_cnt + CW'(1);
      else                                  r_tmo_cnt <= '0;
      if (w_grant)                      r_tmo <= 1'b0;
      else if (w_tmo_hit && !fpu_done)  r_tmo <= 1'b1;
    end
  end

  assign rsp_timeout = r_tmo;
`else
  // Watchdog compiled out; the parameter stays so both builds share one interface.
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
  assign w_tmo_hit    = 1'b0;
  assign rsp_timeout  = 1'b0;
`endif

  assign fpu_in1    = r_a;
  assign fpu_in2    = r_b;
  assign fpu_opcode = r_op;
  assign fpu_round  = r_rm;
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_id     = r_id;
  assign rsp_data   = r_data;
  assign rsp_flags  = r_flags;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_fpu_sched.sv
// Bench for fpu_sched: behavioural FPU model plus a scoreboard of expected
// responses built from the driven stimulus.
module tb_fpu_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [5:0]  req_rm;
  logic [31:0] fpu_in1;
  logic [31:0] fpu_in2;
  logic [2:0]  fpu_opcode;
  logic [2:0]  fpu_round;
  logic        fpu_rstp;
  logic        fpu_act;
  logic [4:0]  fpu_en;
  logic [31:0] fpu_out;
  logic [7:0]  fpu_flags;
  logic        fpu_done;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_flags;
  logic        rsp_timeout;
  logic        busy;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic [7:0]  flags;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_delay = 1;
  bit   hang = 1'b0;
  bit   spur_done = 1'b0;
  int   wcnt = 0;
  bit   en_seen = 1'b0;
  bit   rsp_seen = 1'b0;

  fpu_sched #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm),
    .fpu_in1(fpu_in1), .fpu_in2(fpu_in2), .fpu_opcode(fpu_opcode),
    .fpu_round(fpu_round), .fpu_rstp(fpu_rstp), .fpu_act(fpu_act),
    .fpu_en(fpu_en), .fpu_out(fpu_out), .fpu_flags(fpu_flags),
    .fpu_done(fpu_done), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mdl_out(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [2:0] rm);
    if (op == 3'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return a ^ {b[15:0], b[31:16]} ^ {26'd0, rm, op};
  endfunction

  function automatic logic [7:0] mdl_flags(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    return a[7:0] ^ b[31:24] ^ {5'd0, op};
  endfunction

  // FPU model: result follows its inputs; done fires done_delay cycles into WAIT.
  always @(negedge clk) begin
    fpu_out   = mdl_out(fpu_opcode, fpu_in1, fpu_in2, fpu_round);
    fpu_flags = mdl_flags(fpu_opcode, fpu_in1, fpu_in2);
    if (fpu_act) wcnt = wcnt + 1;
    else         wcnt = 0;
    fpu_done = spur_done | (fpu_act && !hang && wcnt == done_delay);
    if (fpu_en != 5'd0) en_seen = 1'b1;
    if (rsp_valid)      rsp_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] rm);
    req_op[3*r +: 3]  = op;
    req_a[32*r +: 32] = a;
    req_b[32*r +: 32] = b;
    req_rm[3*r +: 3]  = rm;
  endtask

  function automatic exp_t mk_exp(input int r);
    logic [2:0]  op;
    logic [2:0]  rm;
    logic [31:0] a;
    logic [31:0] b;
    op = req_op[3*r +: 3];
    rm = req_rm[3*r +: 3];
    a  = req_a[32*r +: 32];
    b  = req_b[32*r +: 32];
    return {1'(r), mdl_out(op, a, b, rm), mdl_flags(op, a, b), 1'b0};
  endfunction

  task automatic test_reset();
    rstn = 1'b0; req_valid = 2'b11; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_req_ready: got %b want 00", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (rsp_valid !== 1'b0 || rsp_timeout !== 1'b0) begin bad++; $display("FAIL rst_rsp: got valid=%b tmo=%b want 0 0", rsp_valid, rsp_timeout); end
    total++; if (fpu_rstp !== 1'b1 || fpu_act !== 1'b0 || fpu_en !== 5'd0) begin bad++; $display("FAIL rst_fpu_ctl: got rstp=%b act=%b en=%b want 1 0 00000", fpu_rstp, fpu_act, fpu_en); end
    total++; if (rsp_data !== 32'd0 || rsp_flags !== 8'd0 || fpu_in1 !== 32'd0) begin bad++; $display("FAIL rst_data: got data=%h flags=%h in1=%h want zeros", rsp_data, rsp_flags, fpu_in1); end
    req_valid = 2'b00;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    exp_t e;
    exp_t got;
    int   gid;
    done_delay = 1; rsp_ready = 1'b1;
    set_req(0, 3'd1, 32'h11110000, 32'h00002222, 3'd1);
    set_req(1, 3'd2, 32'h33330000, 32'h00004444, 3'd2);
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      int exp_id;
      int k;
      exp_id = i % 2;
      k = 0;
      while (req_ready == 2'b00 && k < 20) begin tick(); k++; end
      total++; if (req_ready !== (2'b01 << exp_id)) begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", i, req_ready, 2'b01 << exp_id); end
      gid = req_ready[1] ? 1 : 0;
      sb.push_back(mk_exp(gid));
      tick();
      k = 0;
      while (!rsp_valid && k < 40) begin tick(); k++; end
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rr_rsp_wait[%0d]: got valid=%b want 1", i, rsp_valid); end
      got = {rsp_id, rsp_data, rsp_flags, rsp_timeout};
      e = sb.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL rr_rsp[%0d]: got id=%0d data=%h flags=%h tmo=%b want id=%0d data=%h flags=%h tmo=%b", i, got.id, got.data, got.flags, got.tmo, e.id, e.data, e.flags, e.tmo); end
      set_req(gid, 3'(gid + 1), 32'h01010101 * (i + 5), 32'h0F0F0000 + i, 3'(i));
      if (i == 3) req_valid = 2'b00;
      tick();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_add();
    exp_t e;
    exp_t got;
    int   t0;
    int   k;
    set_req(0, 3'd0, 32'h3F800000, 32'h40000000, 3'd0);
    req_valid = 2'b01; done_delay = 3; rsp_ready = 1'b0;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL add_grant: got %b want 01", req_ready); end
    t0 = cyc;
    sb.push_back({1'b0, 32'h40400000, mdl_flags(3'd0, 32'h3F800000, 32'h40000000), 1'b0});
    spur_done = 1'b1;
    tick();
    req_valid = 2'b00;
    total++; if (fpu_rstp !== 1'b1 || fpu_act !== 1'b0 || fpu_en !== 5'd0 || fpu_in1 !== 32'h3F800000 || fpu_in2 !== 32'h40000000) begin bad++; $display("FAIL add_launch: got rstp=%b act=%b en=%b in1=%h in2=%h want 1 0 00000 3f800000 40000000", fpu_rstp, fpu_act, fpu_en, fpu_in1, fpu_in2); end
    tick();
    spur_done = 1'b0;
    total++; if (fpu_en !== 5'b00001 || fpu_act !== 1'b1 || fpu_rstp !== 1'b0 || fpu_opcode !== 3'd0) begin bad++; $display("FAIL add_wait: got en=%b act=%b rstp=%b op=%0d want 00001 1 0 0", fpu_en, fpu_act, fpu_rstp, fpu_opcode); end
    k = 0;
    while (!rsp_valid && k < 20) begin tick(); k++; end
    total++; if (cyc - t0 != 5) begin bad++; $display("FAIL add_latency: got %0d want 5", cyc - t0); end
    got = {rsp_id, rsp_data, rsp_flags, rsp_timeout};
    e = sb.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL add_rsp: got id=%0d data=%h flags=%h tmo=%b want id=%0d data=%h flags=%h tmo=%b", got.id, got.data, got.flags, got.tmo, e.id, e.data, e.flags, e.tmo); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL add_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    exp_t snap;
    int   k;
    set_req(1, 3'd4, 32'h0000ABCD, 32'h12345678, 3'd3);
    set_req(0, 3'd1, 32'h55555555, 32'h66666666, 3'd0);
    req_valid = 2'b11; done_delay = 2; rsp_ready = 1'b0;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL bp_grant: got %b want 10", req_ready); end
    sb.push_back(mk_exp(1));
    tick();
    tick();
    total++; if (fpu_en !== 5'b10000) begin bad++; $display("FAIL bp_en: got %b want 10000", fpu_en); end
    k = 0;
    while (!rsp_valid && k < 20) begin tick(); k++; end
    snap = {rsp_id, rsp_data, rsp_flags, rsp_timeout};
    e = sb.pop_front();
    total++; if (rsp_valid !== 1'b1 || snap !== e) begin bad++; $display("FAIL bp_rsp: got valid=%b id=%0d data=%h flags=%h want 1 id=%0d data=%h flags=%h", rsp_valid, snap.id, snap.data, snap.flags, e.id, e.data, e.flags); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (rsp_valid !== 1'b1 || {rsp_id, rsp_data, rsp_flags, rsp_timeout} !== snap || req_ready !== 2'b00) begin bad++; $display("FAIL bp_hold[%0d]: got valid=%b data=%h flags=%h ready=%b want 1 %h %h 00", i, rsp_valid, rsp_data, rsp_flags, req_ready, snap.data, snap.flags); end
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got valid=%b want 0", rsp_valid); end
  endtask

  task automatic test_bad_op();
    exp_t e;
    exp_t got;
    int   t0;
    set_req(1, 3'd5, 32'hDEADBEEF, 32'hCAFEF00D, 3'd1);
    req_valid = 2'b10; rsp_ready = 1'b0; en_seen = 1'b0;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL bad_grant: got %b want 10", req_ready); end
    t0 = cyc;
    sb.push_back({1'b1, 32'd0, 8'h20, 1'b0});
    tick();
    req_valid = 2'b00;
    total++; if (rsp_valid !== 1'b1 || cyc - t0 != 1) begin bad++; $display("FAIL bad_latency: got valid=%b lat=%0d want 1 1", rsp_valid, cyc - t0); end
    got = {rsp_id, rsp_data, rsp_flags, rsp_timeout};
    e = sb.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL bad_rsp: got id=%0d data=%h flags=%h want id=%0d data=%h flags=%h", got.id, got.data, got.flags, e.id, e.data, e.flags); end
    total++; if (fpu_rstp !== 1'b1 || fpu_act !== 1'b0) begin bad++; $display("FAIL bad_fpu_ctl: got rstp=%b act=%b want 1 0", fpu_rstp, fpu_act); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
    total++; if (en_seen !== 1'b0) begin bad++; $display("FAIL bad_en: got en_seen=%b want 0", en_seen); end
  endtask

  task automatic test_timeout();
    set_req(0, 3'd3, 32'h40800000, 32'h00000000, 3'd2);
    req_valid = 2'b01; hang = 1'b1; rsp_ready = 1'b0;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL tmo_grant: got %b want 01", req_ready); end
`ifdef FPU_SCHED_TIMEOUT_EN
    begin
      exp_t e;
      exp_t got;
      int   t0;
      int   k;
      t0 = cyc;
      sb.push_back({1'b0, 32'd0, 8'd0, 1'b1});
      tick();
      req_valid = 2'b00;
      tick();
      total++; if (fpu_en !== 5'b00100) begin bad++; $display("FAIL tmo_en: got %b want 00100", fpu_en); end
      k = 0;
      while (!rsp_valid && k < 200) begin tick(); k++; end
      total++; if (rsp_valid !== 1'b1 || cyc - t0 != 66) begin bad++; $display("FAIL tmo_latency: got valid=%b lat=%0d want 1 66", rsp_valid, cyc - t0); end
      got = {rsp_id, rsp_data, rsp_flags, rsp_timeout};
      e = sb.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL tmo_rsp: got id=%0d data=%h flags=%h tmo=%b want id=%0d data=%h flags=%h tmo=%b", got.id, got.data, got.flags, got.tmo, e.id, e.data, e.flags, e.tmo); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      hang = 1'b0;
    end
`else
    tick();
    req_valid = 2'b00;
    repeat (1000) tick();
    total++; if (fpu_act !== 1'b1 || busy !== 1'b1 || rsp_valid !== 1'b0 || fpu_en !== 5'b00100 || rsp_timeout !== 1'b0) begin bad++; $display("FAIL tmo_wait: got act=%b busy=%b valid=%b en=%b tmo=%b want 1 1 0 00100 0", fpu_act, busy, rsp_valid, fpu_en, rsp_timeout); end
`endif
  endtask

  task automatic test_reset_mid();
    exp_t e;
    exp_t got;
    int   k;
    if (!busy) begin
      set_req(0, 3'd0, 32'h11111111, 32'h22222222, 3'd0);
      req_valid = 2'b01; hang = 1'b1;
      #1;
      tick();
      req_valid = 2'b00;
      tick();
      tick();
    end
    total++; if (fpu_act !== 1'b1) begin bad++; $display("FAIL rm_pre: got act=%b want 1", fpu_act); end
    #2;
    rstn = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || fpu_rstp !== 1'b1 || fpu_act !== 1'b0 || fpu_en !== 5'd0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL rm_async: got busy=%b rstp=%b act=%b en=%b valid=%b want 0 1 0 00000 0", busy, fpu_rstp, fpu_act, fpu_en, rsp_valid); end
    hang = 1'b0;
    rsp_seen = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (3) tick();
    total++; if (rsp_seen !== 1'b0) begin bad++; $display("FAIL rm_no_rsp: got rsp_seen=%b want 0", rsp_seen); end
    set_req(0, 3'd1, 32'h0BADF00D, 32'h00C0FFEE, 3'd4);
    set_req(1, 3'd0, 32'h77777777, 32'h88888888, 3'd5);
    req_valid = 2'b11; done_delay = 1; rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rm_tie: got %b want 01", req_ready); end
    sb.push_back(mk_exp(0));
    tick();
    req_valid = 2'b00;
    k = 0;
    while (!rsp_valid && k < 20) begin tick(); k++; end
    got = {rsp_id, rsp_data, rsp_flags, rsp_timeout};
    e = sb.pop_front();
    total++; if (rsp_valid !== 1'b1 || got !== e) begin bad++; $display("FAIL rm_rsp: got valid=%b id=%0d data=%h flags=%h want 1 id=%0d data=%h flags=%h", rsp_valid, got.id, got.data, got.flags, e.id, e.data, e.flags); end
    tick();
    rsp_ready = 1'b0;
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_left: got %0d entries want 0", sb.size()); end
  endtask

  initial begin
    rstn = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; req_rm = '0;
    fpu_out = '0; fpu_flags = '0; fpu_done = 1'b0;
    test_reset();
    test_round_robin();
    test_add();
    test_backpressure();
    test_bad_op();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
